// File: rtl/master_port_if.sv
// Request-side and serial-bus-side signals of master_port, bundled as one port.
// The master modport is the initiator's view; slave is the view of whatever drives it.
interface master_port_if #(
  parameter int ADDR_W = 15
);
  logic              M_REQ;
  logic              M_RW;
  logic [ADDR_W-1:0] M_ADDR;
  logic [7:0]        M_DIN;
  logic              M_READY;
  logic              M_DONE;
  logic [7:0]        M_DOUT;
  logic              M_ERR;
  logic              AD_SEL;
  logic              B_RW;
  logic              B_BUS_OUT;
  logic              B_BUS_IN;
  logic              B_ACK;

  modport master (
    input  M_REQ, M_RW, M_ADDR, M_DIN, B_BUS_IN, B_ACK,
    output M_READY, M_DONE, M_DOUT, M_ERR, AD_SEL, B_RW, B_BUS_OUT
  );

  modport slave (
    output M_REQ, M_RW, M_ADDR, M_DIN, B_BUS_IN, B_ACK,
    input  M_READY, M_DONE, M_DOUT, M_ERR, AD_SEL, B_RW, B_BUS_OUT
  );
endinterface

// File: rtl/master_port.sv
// Serial bus initiator: shifts out a 15-bit address and a write byte LSB first,
// waits for the slave ACK with a timeout, and deserialises a read byte.
module master_port #(
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = 16,
  parameter int RD_LAT  = 1
) (
  input  logic          CLK,
  input  logic          RST,
  master_port_if.master bus
);
  localparam int CNT_W  = $clog2(ADDR_W) + 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  BYTE_LAST = CNT_W'(8);
  localparam logic [CNT_W-1:0]  SKIP_LAST = CNT_W'(RD_LAT);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, ADDR, WAIT_AACK, WDATA, WAIT_WACK, RSKIP, RDATA, FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
  logic [7:0]        din_sh_q, din_sh_d;
  logic [7:0]        rd_sh_q, rd_sh_d;
  logic [7:0]        dout_q, dout_d;
  logic              rw_q, rw_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
  logic              ad_sel_q, ad_sel_d;
  logic              b_rw_q, b_rw_d;
  logic              bus_out_q, bus_out_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              timed_out;

  // Saturating wait count; the expiry test includes the current cycle.
  assign wait_inc  = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
  assign timed_out = (wait_inc == WAIT_MAX);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    addr_sh_d  = addr_sh_q;
    din_sh_d   = din_sh_q;
    rd_sh_d    = rd_sh_q;
    dout_d     = dout_q;
    rw_d       = rw_q;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    ad_sel_d   = ad_sel_q;
    b_rw_d     = b_rw_q;
    bus_out_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.M_REQ) begin
          state_d   = ADDR;
          addr_sh_d = bus.M_ADDR >> 1;
          bus_out_d = bus.M_ADDR[0];
          din_sh_d  = bus.M_DIN;
          rw_d      = bus.M_RW;
          b_rw_d    = bus.M_RW;
          ad_sel_d  = 1'b1;
          bit_cnt_d = CNT_ONE;
        end
      end
      ADDR: begin
        if (bit_cnt_q == ADDR_LAST) begin
          state_d    = WAIT_AACK;
          wait_cnt_d = '0;
        end else begin
          bus_out_d = addr_sh_q[0];
          addr_sh_d = addr_sh_q >> 1;
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end
      WAIT_AACK: begin
        if (bus.B_ACK) begin
          wait_cnt_d = '0;
          bit_cnt_d  = '0;
          if (rw_q) begin
            state_d   = WDATA;
            bus_out_d = din_sh_q[0];
            din_sh_d  = din_sh_q >> 1;
            bit_cnt_d = CNT_ONE;
          end else begin
            state_d = (RD_LAT == 0) ? RDATA : RSKIP;
          end
        end else if (timed_out) begin
          state_d  = IDLE;
          ad_sel_d = 1'b0;
          b_rw_d   = 1'b0;
          err_d    = 1'b1;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      WDATA: begin
        if (bit_cnt_q == BYTE_LAST) begin
          state_d    = WAIT_WACK;
          wait_cnt_d = '0;
        end else begin
          bus_out_d = din_sh_q[0];
          din_sh_d  = din_sh_q >> 1;
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end
      WAIT_WACK: begin
        if (bus.B_ACK) begin
          state_d  = FINISH;
          ad_sel_d = 1'b0;
          b_rw_d   = 1'b0;
        end else if (timed_out) begin
          state_d  = IDLE;
          ad_sel_d = 1'b0;
          b_rw_d   = 1'b0;
          err_d    = 1'b1;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      RSKIP: begin
        if (bit_cnt_q + CNT_ONE == SKIP_LAST) begin
          state_d   = RDATA;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end
      RDATA: begin
        // One trailing cycle after the eighth sample before FINISH.
        if (bit_cnt_q == BYTE_LAST) begin
          state_d  = FINISH;
          ad_sel_d = 1'b0;
          b_rw_d   = 1'b0;
        end else begin
          rd_sh_d   = {bus.B_BUS_IN, rd_sh_q[7:1]};
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!rw_q) dout_d = rd_sh_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      addr_sh_q  <= '0;
      din_sh_q   <= '0;
      rd_sh_q    <= '0;
      dout_q     <= '0;
      rw_q       <= 1'b0;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      ad_sel_q   <= 1'b0;
      b_rw_q     <= 1'b0;
      bus_out_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_sh_q  <= addr_sh_d;
      din_sh_q   <= din_sh_d;
      rd_sh_q    <= rd_sh_d;
      dout_q     <= dout_d;
      rw_q       <= rw_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      ad_sel_q   <= ad_sel_d;
      b_rw_q     <= b_rw_d;
      bus_out_q  <= bus_out_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.M_READY   = (state_q == IDLE);
  assign bus.M_DONE    = done_q;
  assign bus.M_DOUT    = dout_q;
  assign bus.M_ERR     = err_q;
  assign bus.AD_SEL    = ad_sel_q;
  assign bus.B_RW      = b_rw_q;
  assign bus.B_BUS_OUT = bus_out_q;
endmodule
